decode_scoreboard: RTL and testbench
====================================

Name: decode_scoreboard

Overview:
- Parametrised hazard scoreboard for the decode stage. It generalises the fixed two-source, load-only bubble check to NSRC sources and variable producer latency (load, multiply, divide, CSR).
- Per architectural register it tracks the in-flight producer, its tag and the cycles until the result reaches the bypass network.
- Decode asserts one issue request per cycle. The block returns a stall and per-source forward-hit flags, and clears entries on tagged writeback or pipeline flush.

Parameters:
- NREG, 32, number of architectural registers; index width RW = $clog2(NREG).
- NSRC, 2, source operands checked per issue.
- LATW, 3, width of the latency countdown.
- TAGW, 4, producer tag width.
- ZERO_REG, 1, when 1 register 0 is never busy and never stalls.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_wen  in  1  instruction writes a register.
- issue_dst  in  RW  destination register.
- issue_lat  in  LATW  cycles until result is forwardable; 0 = ALU (forwardable next cycle).
- issue_tag  in  TAGW  producer tag stored with the entry.
- src_used  in  NSRC  per-source "operand read" flag.
- src_idx  in  NSRC*RW  packed source indices; source i at [i*RW +: RW].
- stall  out  1  combinational; issue not accepted this cycle.
- fwd_hit  out  NSRC  combinational; source i has a READY producer and must take bypass data.
- wb_valid  in  1  writeback retires a producer.
- wb_dst  in  RW  writeback register.
- wb_tag  in  TAGW  writeback tag.
- flush  in  1  kill all in-flight producers.
- busy_vec  out  NREG  registered; bit r = entry r not IDLE.
- stall_count  out  32  registered saturating count of cycles with issue_valid && stall.

Behaviour:
- Each entry holds: state {IDLE, WAIT, READY}, cnt[LATW], tag[TAGW].
- Reset (asynchronous, reset==0): all entries IDLE, cnt=0, tag=0, busy_vec=0, stall_count=0. Deasserting reset takes effect at the next edge.
- Source i is hazardous when src_used[i] is set, src_idx i is not register 0 (ZERO_REG=1), and entry[src] is in WAIT.
- fwd_hit[i] = src_used[i] && entry[src].state==READY (register-0 and ZERO_REG masking also applies). It does not depend on issue_valid.
- stall = issue_valid && (any source hazardous || (issue_wen && entry[issue_dst].state==WAIT)). The second term is WAW ordering against a slower producer.
- accept = issue_valid && !stall && !flush.
- Per-edge priority, highest first:
  1. flush: every entry becomes IDLE; same-cycle issue and wb are ignored.
  2. accepted issue with issue_wen and a non-zero dst: entry[dst] ← WAIT with cnt=issue_lat if issue_lat>0, otherwise READY; tag ← issue_tag.
  3. wb_valid: if entry[wb_dst] is not IDLE and its tag==wb_tag, the entry becomes IDLE. Otherwise wb is ignored (stale or older producer).
  4. Countdown, applied to every entry in WAIT that was not written in steps 1–3: cnt decrements; when cnt==1 the entry moves to READY.
- Issue and wb to the same register in the same cycle: issue wins and wb is dropped, even when tags match.
- ZERO_REG=1: issue to register 0 never allocates an entry.
- stall_count increments when issue_valid && stall and saturates at 0xFFFF_FFFF. flush does not clear it.
- Stalled or non-accepted issue causes no state change.
- Latency issue_lat=N: the first consumer without stall issues N cycles after the producer issue edge, and sees fwd_hit=1.

Test Plan:
- Reset release → busy_vec=0, stall_count=0. Issue dst=5, lat=0, tag=3; next cycle src0=5 used → stall=0, fwd_hit[0]=1, busy_vec[5]=1.
- Issue dst=7, lat=2. Consumer src1=7 held at issue_valid → stall=1 for 2 cycles, then stall=0 with fwd_hit[1]=1; stall_count=2.
- Issue dst=9 tag=1, then re-issue dst=9 tag=2 after READY. wb dst=9 tag=1 → ignored, busy_vec[9]=1. wb tag=2 → busy_vec[9]=0.
- Entries dst=3 (WAIT) and dst=4 (READY) in flight. flush together with issue dst=6 and wb dst=4 → busy_vec=0 next cycle, register 6 not allocated.
- ZERO_REG=1: issue dst=0 lat=3 → busy_vec=0. A consumer with src=0 never stalls and has fwd_hit=0.
- Assert reset mid-countdown (entry dst=2, cnt=2) asynchronously → busy_vec=0 immediately without a clock edge, and stall=0 for src=2.

Source files
------------

// File: rtl/decode_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight producers per register and
// reports RAW/WAW stalls and bypass hits for NSRC source operands.
module decode_scoreboard #(
    parameter int NREG     = 32,
    parameter int NSRC     = 2,
    parameter int LATW     = 3,
    parameter int TAGW     = 4,
    parameter bit ZERO_REG = 1'b1,
    localparam int RW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_wen,
    input  logic [RW-1:0]       issue_dst,
    input  logic [LATW-1:0]     issue_lat,
    input  logic [TAGW-1:0]     issue_tag,
    input  logic [NSRC-1:0]     src_used,
    input  logic [NSRC*RW-1:0]  src_idx,
    output logic                stall,
    output logic [NSRC-1:0]     fwd_hit,
    input  logic                wb_valid,
    input  logic [RW-1:0]       wb_dst,
    input  logic [TAGW-1:0]     wb_tag,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec,
    output logic [31:0]         stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } entry_state_t;

    entry_state_t        state_q [NREG];
    logic [LATW-1:0]     cnt_q   [NREG];
    logic [TAGW-1:0]     tag_q   [NREG];

    logic [NSRC-1:0]     src_hazard;
    logic                waw_hazard;
    logic                accept;
    logic                alloc;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [RW-1:0] idx;
        logic          masked;

        assign idx    = src_idx[i*RW +: RW];
        assign masked = ZERO_REG && (idx == '0);

        assign src_hazard[i] = src_used[i] && !masked && (state_q[idx] == WAIT);
        assign fwd_hit[i]    = src_used[i] && !masked && (state_q[idx] == READY);
    end

    // A new writer must not overtake a slower producer of the same register.
    assign waw_hazard = issue_wen && (state_q[issue_dst] == WAIT);
    assign stall      = issue_valid && ((|src_hazard) || waw_hazard);
    assign accept     = issue_valid && !stall && !flush;
    assign alloc      = accept && issue_wen && !(ZERO_REG && (issue_dst == '0));

    for (genvar r = 0; r < NREG; r++) begin : g_busy
        assign busy_vec[r] = (state_q[r] != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                state_q[r] <= IDLE;
                cnt_q[r]   <= '0;
                tag_q[r]   <= '0;
            end
            stall_count <= '0;
        end else begin
            if (issue_valid && stall && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end

            // Priority per entry: flush, allocation, tagged writeback, countdown.
            for (int r = 0; r < NREG; r++) begin
                if (flush) begin
                    state_q[r] <= IDLE;
                    cnt_q[r]   <= '0;
                end else if (alloc && (issue_dst == RW'(r))) begin
                    tag_q[r] <= issue_tag;
                    if (issue_lat != '0) begin
                        state_q[r] <= WAIT;
                        cnt_q[r]   <= issue_lat;
                    end else begin
                        state_q[r] <= READY;
                        cnt_q[r]   <= '0;
                    end
                end else if (wb_valid && (wb_dst == RW'(r)) &&
                             (state_q[r] != IDLE) && (tag_q[r] == wb_tag)) begin
                    state_q[r] <= IDLE;
                    cnt_q[r]   <= '0;
                end else if (state_q[r] == WAIT) begin
                    if (cnt_q[r] <= LATW'(1)) begin
                        state_q[r] <= READY;
                        cnt_q[r]   <= '0;
                    end else begin
                        cnt_q[r] <= cnt_q[r] - LATW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard bench for decode_scoreboard: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_decode_scoreboard;

    localparam int NREG = 32;
    localparam int NSRC = 2;
    localparam int LATW = 3;
    localparam int TAGW = 4;
    localparam int RW   = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                issue_valid = 1'b0;
    logic                issue_wen = 1'b0;
    logic [RW-1:0]       issue_dst = '0;
    logic [LATW-1:0]     issue_lat = '0;
    logic [TAGW-1:0]     issue_tag = '0;
    logic [NSRC-1:0]     src_used = '0;
    logic [NSRC*RW-1:0]  src_idx = '0;
    logic                stall;
    logic [NSRC-1:0]     fwd_hit;
    logic                wb_valid = 1'b0;
    logic [RW-1:0]       wb_dst = '0;
    logic [TAGW-1:0]     wb_tag = '0;
    logic                flush = 1'b0;
    logic [NREG-1:0]     busy_vec;
    logic [31:0]         stall_count;

    always #5 clk = ~clk;

    decode_scoreboard #(
        .NREG(NREG), .NSRC(NSRC), .LATW(LATW), .TAGW(TAGW), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dst(issue_dst),
        .issue_lat(issue_lat), .issue_tag(issue_tag),
        .src_used(src_used), .src_idx(src_idx),
        .stall(stall), .fwd_hit(fwd_hit),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_tag(wb_tag),
        .flush(flush), .busy_vec(busy_vec), .stall_count(stall_count)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] value;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic logic [31:0] bits(input int a, input int b, input int c, input int d);
        logic [31:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    task automatic push_expect(input logic [1:0] kind, input logic [31:0] value, input string name);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // One expectation per output, all observed at the next falling edge.
    task automatic expect_all(input string step, input logic exp_stall, input logic [1:0] exp_fwd,
                              input logic [31:0] exp_busy, input logic [31:0] exp_cnt);
        push_expect(2'd0, {31'd0, exp_stall}, {step, "_stall"});
        push_expect(2'd1, {30'd0, exp_fwd}, {step, "_fwd"});
        push_expect(2'd2, exp_busy, {step, "_busy"});
        push_expect(2'd3, exp_cnt, {step, "_cnt"});
    endtask

    task automatic apply_stimulus(input logic v, input logic wen, input logic [RW-1:0] dst,
                                  input logic [LATW-1:0] lat, input logic [TAGW-1:0] tag,
                                  input logic [1:0] used, input logic [RW-1:0] s0,
                                  input logic [RW-1:0] s1, input logic wbv,
                                  input logic [RW-1:0] wbd, input logic [TAGW-1:0] wbt,
                                  input logic fl);
        @(posedge clk);
        #1;
        issue_valid = v;
        issue_wen   = wen;
        issue_dst   = dst;
        issue_lat   = lat;
        issue_tag   = tag;
        src_used    = used;
        src_idx     = {s1, s0};
        wb_valid    = wbv;
        wb_dst      = wbd;
        wb_tag      = wbt;
        flush       = fl;
    endtask

    task automatic check_output(input exp_t e, input string name);
        logic [31:0] actual;
        case (e.kind)
            2'd0:    actual = {31'd0, stall};
            2'd1:    actual = {30'd0, fwd_hit};
            2'd2:    actual = busy_vec;
            default: actual = stall_count;
        endcase
        checks++;
        if (actual !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, e.value);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                check_output(exp_q.pop_front(), name_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);

        // Reset release and single-cycle ALU producer.
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        expect_all("rst", 0, 2'b00, 32'd0, 32'd0);
        apply_stimulus(1, 1, 5, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("a1", 0, 2'b00, 32'd0, 32'd0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0);
        expect_all("a2", 0, 2'b01, bits(5, -1, -1, -1), 32'd0);

        // Two-cycle producer, consumer on source 1 held until ready.
        apply_stimulus(1, 1, 7, 2, 5, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("b1", 0, 2'b00, bits(5, -1, -1, -1), 32'd0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b10, 0, 7, 0, 0, 0, 0);
        expect_all("b2", 1, 2'b00, bits(5, 7, -1, -1), 32'd0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b10, 0, 7, 0, 0, 0, 0);
        expect_all("b3", 1, 2'b00, bits(5, 7, -1, -1), 32'd1);
        apply_stimulus(1, 0, 0, 0, 0, 2'b10, 0, 7, 0, 0, 0, 0);
        expect_all("b4", 0, 2'b10, bits(5, 7, -1, -1), 32'd2);

        // Tagged writeback: stale tag ignored, matching tag retires.
        apply_stimulus(1, 1, 9, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("c1", 0, 2'b00, bits(5, 7, -1, -1), 32'd2);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("c2", 0, 2'b00, bits(5, 7, 9, -1), 32'd2);
        apply_stimulus(1, 1, 9, 0, 2, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("c3", 0, 2'b00, bits(5, 7, 9, -1), 32'd2);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 9, 1, 0);
        expect_all("c4", 0, 2'b00, bits(5, 7, 9, -1), 32'd2);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 9, 2, 0);
        expect_all("c5", 0, 2'b00, bits(5, 7, 9, -1), 32'd2);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("c6", 0, 2'b00, bits(5, 7, -1, -1), 32'd2);

        // Flush overrides a same-cycle issue and writeback.
        apply_stimulus(1, 1, 3, 3, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("d1", 0, 2'b00, bits(5, 7, -1, -1), 32'd2);
        apply_stimulus(1, 1, 4, 0, 2, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("d2", 0, 2'b00, bits(3, 5, 7, -1), 32'd2);
        apply_stimulus(1, 1, 6, 0, 4, 2'b00, 0, 0, 1, 4, 2, 1);
        expect_all("d3", 0, 2'b00, bits(3, 4, 5, 7), 32'd2);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("d4", 0, 2'b00, 32'd0, 32'd2);

        // Register 0 never allocates and never stalls.
        apply_stimulus(1, 1, 0, 3, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("e1", 0, 2'b00, 32'd0, 32'd2);
        apply_stimulus(1, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        expect_all("e2", 0, 2'b00, 32'd0, 32'd2);

        // WAW stall behind a slower producer, then issue beating writeback.
        apply_stimulus(1, 1, 8, 2, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("e3", 0, 2'b00, 32'd0, 32'd2);
        apply_stimulus(1, 1, 8, 0, 2, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("e4", 1, 2'b00, bits(8, -1, -1, -1), 32'd2);
        apply_stimulus(1, 1, 8, 0, 2, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("e5", 1, 2'b00, bits(8, -1, -1, -1), 32'd3);
        apply_stimulus(1, 1, 8, 0, 2, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("e6", 0, 2'b00, bits(8, -1, -1, -1), 32'd4);
        apply_stimulus(1, 1, 8, 0, 3, 2'b00, 0, 0, 1, 8, 2, 0);
        expect_all("e7", 0, 2'b00, bits(8, -1, -1, -1), 32'd4);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 8, 2, 0);
        expect_all("e8", 0, 2'b00, bits(8, -1, -1, -1), 32'd4);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 8, 3, 0);
        expect_all("e9", 0, 2'b00, bits(8, -1, -1, -1), 32'd4);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("e10", 0, 2'b00, 32'd0, 32'd4);

        // Asynchronous reset in the middle of a countdown.
        apply_stimulus(1, 1, 2, 3, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("f1", 0, 2'b00, 32'd0, 32'd4);
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_all("f2", 0, 2'b00, bits(2, -1, -1, -1), 32'd4);
        apply_stimulus(1, 0, 0, 0, 0, 2'b01, 2, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        expect_all("f3", 0, 2'b00, 32'd0, 32'd0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b01, 2, 0, 0, 0, 0, 0);
        reset = 1'b1;
        expect_all("f4", 0, 2'b00, 32'd0, 32'd0);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
